// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store memory controller
package lsu_pkg;

    localparam int LANE_BITS = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_INV  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Alignment fault for a valid size; byte accesses are always aligned.
    function automatic logic misaligned(size_e size, logic [LANE_BITS-1:0] offset);
        case (size)
            SZ_HALF: return offset[0];
            SZ_WORD: return |offset;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - core-side request/response handshake bundle
interface lsu_mem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - sub-word store merge and load extract/extend
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0]          rd_word,
    input  logic [31:0]          wr_data,
    input  size_e                size,
    input  logic [LANE_BITS-1:0] offset,
    input  logic                 is_unsigned,
    output logic [31:0]          merged,
    output logic [31:0]          extracted
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        merged    = rd_word;
        extracted = '0;
        byte_sel  = rd_word[{offset, 3'b000} +: 8];
        half_sel  = rd_word[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                merged[{offset, 3'b000} +: 8] = wr_data[7:0];
                extracted = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                merged[{offset[1], 4'b0000} +: 16] = wr_data[15:0];
                extracted = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                merged    = wr_data;
                extracted = rd_word;
            end
            default: begin
                merged    = rd_word;
                extracted = '0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - blocking load/store controller in front of a word-wide RAM
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_mem_ctrl_if.slave         bus,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("lsu_mem_ctrl supports DATA_WIDTH=32 only");
    end
    if (ADDR_WIDTH > 29 || ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("lsu_mem_ctrl requires 1 <= ADDR_WIDTH <= 29");
    end

    state_e                      state;
    logic                        req_ready_q;
    logic                        rsp_valid_q;
    logic [31:0]                 rsp_rdata_q;
    logic                        rsp_err_q;
    logic                        lat_we;
    size_e                       lat_size;
    logic                        lat_uns;
    logic [ADDR_WIDTH+1:0]       lat_addr;
    logic [31:0]                 lat_wdata;

    size_e                       req_size_e;
    logic                        req_fault;
    logic                        in_access;
    logic [31:0]                 merged_word;
    logic [31:0]                 load_data;

    assign req_size_e = size_e'(bus.req_size);
    assign req_fault  = (req_size_e == SZ_INV)
                     || misaligned(req_size_e, bus.req_addr[LANE_BITS-1:0])
                     || (|bus.req_addr[31:ADDR_WIDTH+LANE_BITS]);

    lsu_lane_align u_lane_align (
        .rd_word     (mem_rdata),
        .wr_data     (lat_wdata),
        .size        (lat_size),
        .offset      (lat_addr[LANE_BITS-1:0]),
        .is_unsigned (lat_uns),
        .merged      (merged_word),
        .extracted   (load_data)
    );

    // RMW is a single combinational path: RAM read at mem_addr feeds the merge, written on the exit edge.
    assign in_access = (state == ACCESS);
    assign mem_we    = in_access & lat_we & ~rst;
    assign mem_addr  = in_access ? lat_addr[ADDR_WIDTH+1:LANE_BITS] : '0;
    assign mem_wdata = mem_we ? merged_word : '0;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            lat_we      <= 1'b0;
            lat_size    <= SZ_BYTE;
            lat_uns     <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we      <= bus.req_we;
                        lat_size    <= req_size_e;
                        lat_uns     <= bus.req_unsigned;
                        lat_addr    <= bus.req_addr[ADDR_WIDTH+1:0];
                        lat_wdata   <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_fault) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= lat_we ? 32'h0 : load_data;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed vector bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

    localparam int AW = 10;
    localparam logic [1:0] SZB = 2'b00;
    localparam logic [1:0] SZH = 2'b01;
    localparam logic [1:0] SZW = 2'b10;
    localparam logic [1:0] SZX = 2'b11;
    localparam int NV = 24;

    typedef struct {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic [31:0]   exp_mwdata;
        logic [AW-1:0] exp_maddr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   ram [0:(1<<AW)-1];

    int            n_checks = 0;
    int            n_fail = 0;
    int            we_cnt = 0;
    logic [31:0]   last_mw;
    logic [AW-1:0] last_ma;
    vec_t          vecs [NV];

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_mw       <= mem_wdata;
            last_ma       <= mem_addr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
    endtask

    task automatic do_req(input vec_t v, output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        drive(v);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, " rsp_err"},   32'(bus.rsp_err), 32'd0);
        check({tag, " mem_we"},    32'(mem_we), 32'd0);
        check({tag, " mem_addr"},  32'(mem_addr), 32'd0);
        check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          base;
        vec_t        v;

        vecs[0]  = '{1'b1, SZW, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 32'hDEADBEEF, 10'd4};
        vecs[1]  = '{1'b0, SZW, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        10'd0};
        vecs[2]  = '{1'b1, SZW, 1'b0, 32'h020, 32'h11223344, 32'h0,        1'b0, 32'h11223344, 10'd8};
        vecs[3]  = '{1'b1, SZB, 1'b0, 32'h022, 32'h555555AA, 32'h0,        1'b0, 32'h11AA3344, 10'd8};
        vecs[4]  = '{1'b0, SZB, 1'b0, 32'h022, 32'h0,        32'hFFFFFFAA, 1'b0, 32'h0,        10'd0};
        vecs[5]  = '{1'b0, SZB, 1'b1, 32'h022, 32'h0,        32'h000000AA, 1'b0, 32'h0,        10'd0};
        vecs[6]  = '{1'b0, SZB, 1'b0, 32'h020, 32'h0,        32'h00000044, 1'b0, 32'h0,        10'd0};
        vecs[7]  = '{1'b0, SZB, 1'b1, 32'h023, 32'h0,        32'h00000011, 1'b0, 32'h0,        10'd0};
        vecs[8]  = '{1'b1, SZW, 1'b0, 32'h030, 32'h0,        32'h0,        1'b0, 32'h0,        10'd12};
        vecs[9]  = '{1'b1, SZH, 1'b0, 32'h032, 32'hCAFE8001, 32'h0,        1'b0, 32'h80010000, 10'd12};
        vecs[10] = '{1'b0, SZH, 1'b0, 32'h032, 32'h0,        32'hFFFF8001, 1'b0, 32'h0,        10'd0};
        vecs[11] = '{1'b0, SZH, 1'b1, 32'h032, 32'h0,        32'h00008001, 1'b0, 32'h0,        10'd0};
        vecs[12] = '{1'b0, SZH, 1'b0, 32'h030, 32'h0,        32'h00000000, 1'b0, 32'h0,        10'd0};
        vecs[13] = '{1'b0, SZW, 1'b0, 32'h030, 32'h0,        32'h80010000, 1'b0, 32'h0,        10'd0};
        vecs[14] = '{1'b1, SZW, 1'b0, 32'h050, 32'h12345678, 32'h0,        1'b0, 32'h12345678, 10'd20};
        vecs[15] = '{1'b1, SZW, 1'b0, 32'hFFC, 32'h0,        32'h0,        1'b0, 32'h0,        10'd1023};
        vecs[16] = '{1'b1, SZB, 1'b0, 32'hFFF, 32'h0000007F, 32'h0,        1'b0, 32'h7F000000, 10'd1023};
        vecs[17] = '{1'b0, SZB, 1'b0, 32'hFFF, 32'h0,        32'h0000007F, 1'b0, 32'h0,        10'd0};
        vecs[18] = '{1'b0, SZH, 1'b0, 32'hFFE, 32'h0,        32'h00007F00, 1'b0, 32'h0,        10'd0};
        vecs[19] = '{1'b0, SZH, 1'b0, 32'h033, 32'h0,        32'h0,        1'b1, 32'h0,        10'd0};
        vecs[20] = '{1'b1, SZW, 1'b0, 32'h042, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        10'd0};
        vecs[21] = '{1'b0, SZX, 1'b0, 32'h010, 32'h0,        32'h0,        1'b1, 32'h0,        10'd0};
        vecs[22] = '{1'b0, SZW, 1'b0, 32'h1000, 32'h0,       32'h0,        1'b1, 32'h0,        10'd0};
        vecs[23] = '{1'b1, SZB, 1'b0, 32'h1003, 32'h000000EE, 32'h0,       1'b1, 32'h0,        10'd0};

        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            base = we_cnt;
            do_req(vecs[i], rd, er, lat);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d latency", i), 32'(lat), vecs[i].exp_err ? 32'd1 : 32'd2);
            check($sformatf("v%0d mem_we cycles", i), 32'(we_cnt - base),
                  (vecs[i].we && !vecs[i].exp_err) ? 32'd1 : 32'd0);
            if (vecs[i].we && !vecs[i].exp_err) begin
                check($sformatf("v%0d mem_wdata", i), last_mw, vecs[i].exp_mwdata);
                check($sformatf("v%0d mem_addr", i), 32'(last_ma), 32'(vecs[i].exp_maddr));
            end
            check($sformatf("v%0d back to idle", i), 32'(bus.req_ready), 32'd1);
        end

        // Backpressure: response held while a competing request waits.
        base = we_cnt;
        v = vecs[1];
        @(negedge clk);
        drive(v);
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        v = '{1'b1, SZW, 1'b0, 32'h010, 32'h0, 32'h0, 1'b0, 32'h0, 10'd0};
        drive(v);
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp latency", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp c%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp c%0d rsp_rdata", c), bus.rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp c%0d req_ready", c), 32'(bus.req_ready), 32'd0);
            check($sformatf("bp c%0d mem_addr", c), 32'(mem_addr), 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("bp release rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp release req_ready", 32'(bus.req_ready), 32'd1);
        check("bp no writes", 32'(we_cnt - base), 32'd0);
        do_req(vecs[1], rd, er, lat);
        check("bp word intact", rd, 32'hDEADBEEF);

        // Reset arriving while a store sits in ACCESS must suppress the write.
        base = we_cnt;
        v = '{1'b1, SZW, 1'b0, 32'h050, 32'hFFFFFFFF, 32'h0, 1'b0, 32'h0, 10'd0};
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_access mem_we pre", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_access mem_we gated", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("rst_access");
        check("rst_access no write", 32'(we_cnt - base), 32'd0);
        v = '{1'b0, SZW, 1'b0, 32'h050, 32'h0, 32'h0, 1'b0, 32'h0, 10'd0};
        do_req(v, rd, er, lat);
        check("rst_access word intact", rd, 32'h12345678);

        // Reset in RESP drops the response without a handshake.
        v = vecs[21];
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst_resp rsp_valid pre", 32'(bus.rsp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_resp rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_resp req_ready", 32'(bus.req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
